// File: rtl/pcm_pkg.sv
// pcm_pkg: shared widths, FSM state type and the Hamming(7,4) encode
// function used by the PCM framer.
//   CW_W      - full codeword width (two 7-bit nibble codes)
//   NIB_CW_W  - per-nibble code width
//   state_e   - framer FSM states
//   hamming74 - nibble -> {p1,p2,d1,p3,d2,d3,d4}
package pcm_pkg;

    localparam int CW_W     = 14;
    localparam int NIB_CW_W = 7;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_e;

    function automatic logic [NIB_CW_W-1:0] hamming74(input logic [3:0] n);
        logic d1, d2, d3, d4, p1, p2, p3;
        d1 = n[3];
        d2 = n[2];
        d3 = n[1];
        d4 = n[0];
        p1 = d1 ^ d2 ^ d4;
        p2 = d1 ^ d3 ^ d4;
        p3 = d2 ^ d3 ^ d4;
        return {p1, p2, d1, p3, d2, d3, d4};
    endfunction

endpackage

// File: rtl/hamming74_enc.sv
// hamming74_enc: combinational Hamming(7,4) encoder for one nibble.
//   nib_i  [3:0]  data nibble (nib_i[3] is d1)
//   code_o [6:0]  codeword {p1,p2,d1,p3,d2,d3,d4}
module hamming74_enc
    import pcm_pkg::*;
(
    input  logic [3:0]          nib_i,
    output logic [NIB_CW_W-1:0] code_o
);

    assign code_o = hamming74(nib_i);

endmodule

// File: rtl/pcm_hamming_framer.sv
// pcm_hamming_framer: captures an 8-bit PCM sample once per character
// period, Hamming(7,4)-encodes both nibbles into a 14-bit codeword and
// shifts it out MSB-first, one bit per bit period. The divider outputs are
// edge-detected level inputs; everything runs on clkIn.
//   clkIn               master clock
//   reset               asynchronous active-high reset
//   clk_bitTransferRate bit-rate square wave (rising edge = next bit)
//   clk_character_rate  character-rate square wave (rising edge = sample)
//   ad_data             PCM sample, stable in the character-tick cycle
//   serial_out          coded serial stream (IDLE_LEVEL between frames)
//   bit_valid           high while serial_out carries a codeword bit
//   frame_sync          high during the first bit (codeword bit 13)
//   overrun             sticky: a pending codeword was overwritten
module pcm_hamming_framer
    import pcm_pkg::*;
#(
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic       clkIn,
    input  logic       reset,
    input  logic       clk_bitTransferRate,
    input  logic       clk_character_rate,
    input  logic [7:0] ad_data,
    output logic       serial_out,
    output logic       bit_valid,
    output logic       frame_sync,
    output logic       overrun
);

    logic            bit_q, char_q;
    logic            bit_tick, char_tick;
    logic [CW_W-1:0] cw_d;
    logic [CW_W-1:0] pend_cw_q;
    logic            pend_v_q;
    logic [CW_W-2:0] shreg_q;     // bit 13 goes out on load, never stored
    logic [3:0]      idx_q;
    state_e          state_q;
    logic            serial_q, valid_q, sync_q, overrun_q;
    logic            frame_end, consume;

    hamming74_enc u_enc_hi (
        .nib_i  (ad_data[7:4]),
        .code_o (cw_d[CW_W-1:NIB_CW_W])
    );

    hamming74_enc u_enc_lo (
        .nib_i  (ad_data[3:0]),
        .code_o (cw_d[NIB_CW_W-1:0])
    );

    assign bit_tick  = clk_bitTransferRate & ~bit_q;
    assign char_tick = clk_character_rate & ~char_q;

    // A bit tick at the last bit of a frame is a load slot just like IDLE,
    // which gives gapless back-to-back frames.
    assign frame_end = (state_q == IDLE) || (idx_q == 4'd13);
    assign consume   = bit_tick && frame_end && pend_v_q;

    always_ff @(posedge clkIn or posedge reset) begin
        if (reset) begin
            bit_q  <= 1'b0;
            char_q <= 1'b0;
        end else begin
            bit_q  <= clk_bitTransferRate;
            char_q <= clk_character_rate;
        end
    end

    // Pending word: a new sample wins over a simultaneous consume; overrun
    // only when the old word is lost rather than handed to the shifter.
    always_ff @(posedge clkIn or posedge reset) begin
        if (reset) begin
            pend_cw_q <= '0;
            pend_v_q  <= 1'b0;
            overrun_q <= 1'b0;
        end else if (char_tick) begin
            pend_cw_q <= cw_d;
            pend_v_q  <= 1'b1;
            if (pend_v_q && !consume) begin
                overrun_q <= 1'b1;
            end
        end else if (consume) begin
            pend_v_q <= 1'b0;
        end
    end

    always_ff @(posedge clkIn or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            idx_q    <= '0;
            serial_q <= IDLE_LEVEL;
            valid_q  <= 1'b0;
            sync_q   <= 1'b0;
        end else if (bit_tick) begin
            if (frame_end) begin
                if (pend_v_q) begin
                    state_q  <= SHIFT;
                    shreg_q  <= pend_cw_q[CW_W-2:0];
                    idx_q    <= '0;
                    serial_q <= pend_cw_q[CW_W-1];
                    valid_q  <= 1'b1;
                    sync_q   <= 1'b1;
                end else begin
                    state_q  <= IDLE;
                    idx_q    <= '0;
                    serial_q <= IDLE_LEVEL;
                    valid_q  <= 1'b0;
                    sync_q   <= 1'b0;
                end
            end else begin
                idx_q    <= idx_q + 4'd1;
                serial_q <= shreg_q[4'd12 - idx_q];
                sync_q   <= 1'b0;
            end
        end
    end

    assign serial_out = serial_q;
    assign bit_valid  = valid_q;
    assign frame_sync = sync_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_pcm_hamming_framer.sv
// Directed bench for pcm_hamming_framer. The bench plays the divider: each
// bit period is 32 clkIn cycles (bit line high for the first 16), and the
// character line follows a per-cycle pattern given to bit_period.
module tb_pcm_hamming_framer;

    logic       clkIn = 1'b0;
    logic       reset;
    logic       bit_lvl;
    logic       chr_lvl;
    logic [7:0] ad_data;
    logic       serial_out, bit_valid, frame_sync, overrun;

    int errors = 0;
    int checks = 0;

    // Outputs sampled just after the bit-tick edge of the latest period.
    logic so_s, bv_s, fs_s;

    localparam logic [31:0] CH_NONE = 32'h0;
    localparam logic [31:0] CH_MID  = 32'h0000_0020;
    localparam logic [31:0] CH_ALL  = 32'hFFFF_FFFF;

    always #5 clkIn = ~clkIn;

    pcm_hamming_framer #(.IDLE_LEVEL(1'b0)) dut (
        .clkIn               (clkIn),
        .reset               (reset),
        .clk_bitTransferRate (bit_lvl),
        .clk_character_rate  (chr_lvl),
        .ad_data             (ad_data),
        .serial_out          (serial_out),
        .bit_valid           (bit_valid),
        .frame_sync          (frame_sync),
        .overrun             (overrun)
    );

    // One bit period; ad_data switches to ad_next at cycle sw (-1: never).
    task automatic bit_period(input logic [31:0] chpat, input int sw,
                              input logic [7:0] ad_next);
        for (int k = 0; k < 32; k++) begin
            bit_lvl = (k < 16);
            chr_lvl = chpat[k];
            if (k == sw) ad_data = ad_next;
            @(posedge clkIn);
            #1;
            if (k == 0) begin
                so_s = serial_out;
                bv_s = bit_valid;
                fs_s = frame_sync;
            end
        end
    endtask

    task automatic test_reset;
        reset   = 1'b1;
        bit_lvl = 1'b0;
        chr_lvl = 1'b0;
        ad_data = 8'h00;
        repeat (3) @(posedge clkIn);
        #1;
        checks++; if (serial_out !== 1'b0) begin errors++; $display("FAIL reset_serial: got %b want 0", serial_out); end
        checks++; if (bit_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bit_valid); end
        checks++; if (frame_sync !== 1'b0) begin errors++; $display("FAIL reset_sync: got %b want 0", frame_sync); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b want 0", overrun); end
        reset = 1'b0;
    endtask

    task automatic test_idle;
        for (int p = 0; p < 100; p++) begin
            bit_period(CH_NONE, -1, 8'h00);
            checks++; if (so_s !== 1'b0) begin errors++; $display("FAIL idle_serial p%0d: got %b want 0", p, so_s); end
            checks++; if (bv_s !== 1'b0) begin errors++; $display("FAIL idle_valid p%0d: got %b want 0", p, bv_s); end
            checks++; if (fs_s !== 1'b0) begin errors++; $display("FAIL idle_sync p%0d: got %b want 0", p, fs_s); end
        end
    endtask

    task automatic test_single_a5;
        logic [13:0] cw;
        cw = 14'h2D25;
        ad_data = 8'hA5;
        bit_period(CH_MID, -1, 8'h00);
        checks++; if (bv_s !== 1'b0) begin errors++; $display("FAIL a5_pre_valid: got %b want 0", bv_s); end
        for (int i = 0; i < 14; i++) begin
            bit_period(CH_NONE, -1, 8'h00);
            checks++; if (so_s !== cw[13-i]) begin errors++; $display("FAIL a5_bit%0d: got %b want %b", 13-i, so_s, cw[13-i]); end
            checks++; if (bv_s !== 1'b1) begin errors++; $display("FAIL a5_valid%0d: got %b want 1", i, bv_s); end
            checks++; if (fs_s !== (i == 0)) begin errors++; $display("FAIL a5_sync%0d: got %b want %b", i, fs_s, (i == 0)); end
        end
        bit_period(CH_NONE, -1, 8'h00);
        checks++; if (bv_s !== 1'b0) begin errors++; $display("FAIL a5_post_valid: got %b want 0", bv_s); end
        checks++; if (so_s !== 1'b0) begin errors++; $display("FAIL a5_post_serial: got %b want 0", so_s); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL a5_overrun: got %b want 0", overrun); end
    endtask

    // Free-running divider: character line high for 7 bit periods, low for 7,
    // its rising edge coincident with a bit tick.
    task automatic test_back_to_back;
        logic [27:0] stream;
        logic        eb;
        stream  = {14'h0000, 14'h3FFF};
        ad_data = 8'h00;
        for (int p = 0; p < 30; p++) begin
            if (p == 7) ad_data = 8'hFF;
            bit_period((p < 21 && (p % 14) < 7) ? CH_ALL : CH_NONE, -1, 8'h00);
            if (p == 0 || p == 29) begin
                checks++; if (bv_s !== 1'b0) begin errors++; $display("FAIL b2b_idle_valid p%0d: got %b want 0", p, bv_s); end
            end else begin
                eb = stream[28-p];
                checks++; if (so_s !== eb) begin errors++; $display("FAIL b2b_bit p%0d: got %b want %b", p, so_s, eb); end
                checks++; if (bv_s !== 1'b1) begin errors++; $display("FAIL b2b_valid p%0d: got %b want 1", p, bv_s); end
                checks++; if (fs_s !== (p == 1 || p == 15)) begin errors++; $display("FAIL b2b_sync p%0d: got %b want %b", p, fs_s, (p == 1 || p == 15)); end
                checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_overrun p%0d: got %b want 0", p, overrun); end
            end
        end
    endtask

    // New sample lands on the same tick that loads the older pending word.
    task automatic test_coincident;
        logic [13:0] exp_cw [3];
        logic        eb;
        exp_cw = '{14'h21BC, 14'h0CE6, 14'h0796};
        ad_data = 8'h3C;
        bit_period(CH_MID, -1, 8'h00);
        for (int p = 1; p < 44; p++) begin
            if (p == 3) begin
                ad_data = 8'h96;
                bit_period(CH_MID, -1, 8'h00);
            end else if (p == 15) begin
                ad_data = 8'h7E;
                bit_period(32'h0000_0001, -1, 8'h00);
            end else begin
                bit_period(CH_NONE, -1, 8'h00);
            end
            if (p == 43) begin
                checks++; if (bv_s !== 1'b0) begin errors++; $display("FAIL coin_post_valid: got %b want 0", bv_s); end
            end else begin
                eb = exp_cw[(p-1)/14][13 - ((p-1) % 14)];
                checks++; if (so_s !== eb) begin errors++; $display("FAIL coin_bit p%0d: got %b want %b", p, so_s, eb); end
                checks++; if (bv_s !== 1'b1) begin errors++; $display("FAIL coin_valid p%0d: got %b want 1", p, bv_s); end
                checks++; if (fs_s !== (((p-1) % 14) == 0)) begin errors++; $display("FAIL coin_sync p%0d: got %b want %b", p, fs_s, (((p-1) % 14) == 0)); end
            end
        end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL coin_overrun: got %b want 0", overrun); end
    endtask

    task automatic test_overrun;
        logic [13:0] cw;
        cw = 14'h21CC;
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_before: got %b want 0", overrun); end
        ad_data = 8'h12;
        bit_period(32'h0010_0008, 10, 8'h34);
        checks++; if (bv_s !== 1'b0) begin errors++; $display("FAIL ovr_pre_valid: got %b want 0", bv_s); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set: got %b want 1", overrun); end
        for (int i = 0; i < 14; i++) begin
            bit_period(CH_NONE, -1, 8'h00);
            checks++; if (so_s !== cw[13-i]) begin errors++; $display("FAIL ovr_bit%0d: got %b want %b", 13-i, so_s, cw[13-i]); end
            checks++; if (fs_s !== (i == 0)) begin errors++; $display("FAIL ovr_sync%0d: got %b want %b", i, fs_s, (i == 0)); end
            checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky%0d: got %b want 1", i, overrun); end
        end
        bit_period(CH_NONE, -1, 8'h00);
        checks++; if (bv_s !== 1'b0) begin errors++; $display("FAIL ovr_post_valid: got %b want 0", bv_s); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_post_sticky: got %b want 1", overrun); end
    endtask

    task automatic test_reset_midframe;
        logic [13:0] cw;
        cw = 14'h0CE6;
        ad_data = 8'hA5;
        bit_period(CH_MID, -1, 8'h00);
        for (int p = 1; p < 8; p++) begin
            if (p == 3) begin
                ad_data = 8'h3C;
                bit_period(CH_MID, -1, 8'h00);
            end else begin
                bit_period(CH_NONE, -1, 8'h00);
            end
        end
        // idx is 6 here; overrun is still set from the previous scenario.
        checks++; if (bv_s !== 1'b1) begin errors++; $display("FAIL rst_mid_valid: got %b want 1", bv_s); end
        #2 reset = 1'b1;
        #1;
        checks++; if (serial_out !== 1'b0) begin errors++; $display("FAIL rst_async_serial: got %b want 0", serial_out); end
        checks++; if (bit_valid !== 1'b0) begin errors++; $display("FAIL rst_async_valid: got %b want 0", bit_valid); end
        checks++; if (frame_sync !== 1'b0) begin errors++; $display("FAIL rst_async_sync: got %b want 0", frame_sync); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rst_async_overrun: got %b want 0", overrun); end
        repeat (2) @(posedge clkIn);
        #1 reset = 1'b0;
        bit_period(CH_NONE, -1, 8'h00);
        checks++; if (bv_s !== 1'b0) begin errors++; $display("FAIL rst_pend_discard: got %b want 0", bv_s); end
        ad_data = 8'h96;
        bit_period(CH_MID, -1, 8'h00);
        for (int i = 0; i < 14; i++) begin
            bit_period(CH_NONE, -1, 8'h00);
            checks++; if (so_s !== cw[13-i]) begin errors++; $display("FAIL rst_bit%0d: got %b want %b", 13-i, so_s, cw[13-i]); end
            checks++; if (bv_s !== 1'b1) begin errors++; $display("FAIL rst_valid%0d: got %b want 1", i, bv_s); end
            checks++; if (fs_s !== (i == 0)) begin errors++; $display("FAIL rst_sync%0d: got %b want %b", i, fs_s, (i == 0)); end
        end
        bit_period(CH_NONE, -1, 8'h00);
        checks++; if (bv_s !== 1'b0) begin errors++; $display("FAIL rst_post_valid: got %b want 0", bv_s); end
    endtask

    initial begin
        test_reset;
        test_idle;
        test_single_a5;
        test_back_to_back;
        test_coincident;
        test_overrun;
        test_reset_midframe;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
